mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
 clk  in  1  single clock, all state on rising edge
 rst  in  1  asynchronous, active-low reset
 aluOut_in  in  32  EX/MEM ALU result; memory address for loads/stores
 gprB_in  in  32  EX/MEM store data
 gprDes_in  in  5  destination register
 BPC_in  in  32  branch target
 zero_in, pcSel_in, nbranch_in  in  1 each  branch condition, branch-instruction flag, branch-on-not-equal flag
 memR_in, memW_in, regW_in, memToR_in  in  1 each  control bits from EX/MEM
 dm_req  out  1  data-memory request
 dm_we  out  1  write enable, valid while dm_req=1
 dm_addr, dm_wdata  out  32 each  address and store data
 dm_ack  in  1  memory completion, one-cycle pulse
 dm_rdata  in  32  load data, valid when dm_ack=1
 stall  out  1  hold upstream registers (EX/MEM Write = ~stall)
 br_taken  out  1  branch resolved taken; drives do_flush upstream
 br_target  out  32  redirect PC
 mw_regW, mw_memToR  out  1 each  MEM/WB control
 mw_gprDes  out  5  MEM/WB destination
 mw_aluOut, mw_rdata  out  32 each  MEM/WB ALU result and load data
 mem_err  out  1  access timeout pulse (see REQ-019)

Function
REQ-002 The FSM SHALL have exactly two states: IDLE and BUSY.
REQ-003 The block SHALL define access = memR_in | memW_in; if both bits are set, the access SHALL be treated as a store.
REQ-004 In IDLE with access=1, the next state SHALL be BUSY, with dm_req=1, dm_we=memW_in, dm_addr=aluOut_in and dm_wdata=gprB_in registered on that edge.
REQ-005 In BUSY, dm_req, dm_we, dm_addr and dm_wdata SHALL hold stable until the dm_ack edge.
REQ-006 On dm_ack=1 in BUSY, the next state SHALL be IDLE, dm_req SHALL fall on that edge, and mw_rdata SHALL capture dm_rdata.
REQ-007 stall SHALL be combinational: stall = (IDLE & access) | (BUSY & ~dm_ack).
REQ-008 A single-cycle-ack access SHALL therefore stall for exactly 2 cycles, and each extra wait cycle SHALL add 1 cycle.
REQ-009 The upstream stage SHALL hold all *_in inputs stable while stall=1; the block SHALL NOT re-issue an access after its ack.
REQ-010 A dm_ack received in IDLE SHALL be ignored.
REQ-011 On every rising edge with stall=0, mw_regW, mw_memToR, mw_gprDes and mw_aluOut SHALL capture regW_in, memToR_in, gprDes_in and aluOut_in; mw_rdata SHALL update only per REQ-006.
REQ-012 On every rising edge with stall=1, the block SHALL insert a bubble: mw_regW=0 and mw_memToR=0, with the other mw_* outputs unchanged.
REQ-013 The result of a load SHALL reach MEM/WB on the same edge as its dm_ack, with mw_memToR=1.
REQ-014 br_taken SHALL be combinational: br_taken = pcSel_in & (zero_in ^ nbranch_in).
REQ-015 br_target SHALL equal BPC_in, and br_taken SHALL be forced to 0 while stall=1.
REQ-016 All arithmetic SHALL be pass-through with no width changes; the block SHALL perform no address alignment checks.

Reset
REQ-017 On rst=0, asynchronously: state=IDLE, dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, all mw_* outputs=0, mem_err=0, and the timeout counter=0.
REQ-018 A reset asserted in BUSY SHALL abort the access with no MEM/WB write; a dm_ack arriving after reset release SHALL be ignored per REQ-010.

Configuration
REQ-019 With macro MEM_TIMEOUT_EN defined, a 4-bit counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack.
- When the counter reaches 15 without dm_ack, the next edge SHALL return the FSM to IDLE, set dm_req=0, and pulse mem_err=1 for exactly one cycle.
- That edge SHALL insert a bubble into MEM/WB, and stall SHALL be 0 during the final timeout cycle.
REQ-020 Without MEM_TIMEOUT_EN, BUSY SHALL wait indefinitely, mem_err SHALL be tied to 0, and no counter SHALL be built.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Load with memR_in=1, aluOut_in=0x100, dm_ack one cycle after dm_req, dm_rdata=0xDEADBEEF -> stall high 2 cycles, dm_addr=0x100, dm_we=0; mw_rdata=0xDEADBEEF and mw_memToR=1 after ack edge.
- Store with memW_in=1, gprB_in=0x12345678, ack after 3 wait cycles -> dm_we=1 and dm_wdata stable 4 cycles; stall high 5 cycles; mw_regW=0 bubbles throughout.
- Branch with pcSel_in=1, zero_in=1, nbranch_in=0, BPC_in=0x40 -> br_taken=1, br_target=0x40; with nbranch_in=1 -> br_taken=0.
- Reset mid-BUSY: rst low for 1 cycle during wait, late dm_ack -> outputs 0, state IDLE, no MEM/WB write.
- MEM_TIMEOUT_EN: request never acked -> dm_req drops after 16 BUSY cycles, mem_err pulses once, stall releases.
- Back-to-back loads with single-cycle ack -> two distinct dm_req assertions, each load data written to MEM/WB exactly once.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues one data-memory access per EX/MEM instruction, stalls upstream until ack,
// resolves branches and fills the MEM/WB register. Define MEM_TIMEOUT_EN to abort accesses unacked for 16 cycles.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] aluOut_in,
    input  logic [31:0] gprB_in,
    input  logic [4:0]  gprDes_in,
    input  logic [31:0] BPC_in,
    input  logic        zero_in,
    input  logic        pcSel_in,
    input  logic        nbranch_in,
    input  logic        memR_in,
    input  logic        memW_in,
    input  logic        regW_in,
    input  logic        memToR_in,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        stall,
    output logic        br_taken,
    output logic [31:0] br_target,
    output logic        mw_regW,
    output logic        mw_memToR,
    output logic [4:0]  mw_gprDes,
    output logic [31:0] mw_aluOut,
    output logic [31:0] mw_rdata,
    output logic        mem_err
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } stateT;

    stateT state;
    stateT nextState;
    logic  access;
    logic  timeoutHit;

    // A set memW_in wins over memR_in, so a request with both bits is a store.
    assign access = memR_in | memW_in;

`ifdef MEM_TIMEOUT_EN
    logic [3:0] waitCnt;

    // Last permitted wait cycle: the exit edge aborts the access instead of stalling again.
    assign timeoutHit = (state == BUSY) & ~dm_ack & (waitCnt == 4'hF);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            waitCnt <= 4'd0;
            mem_err <= 1'b0;
        end else begin
            mem_err <= timeoutHit;
            if (state == IDLE)
                waitCnt <= 4'd0;
            else if (!dm_ack)
                waitCnt <= waitCnt + 4'd1;
        end
    end
`else
    assign timeoutHit = 1'b0;
    assign mem_err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    nextState = BUSY;
                    stall     = 1'b1;
                end
            end
            BUSY: begin
                if (dm_ack || timeoutHit)
                    nextState = IDLE;
                else
                    stall = 1'b1;
            end
            default: nextState = IDLE;
        endcase
    end

    // Branches are never reported while the instruction is stalled, so the flush happens only once.
    assign br_taken  = pcSel_in & (zero_in ^ nbranch_in) & ~stall;
    assign br_target = BPC_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= 32'd0;
            dm_wdata <= 32'd0;
        end else if (state == IDLE && access) begin
            dm_req   <= 1'b1;
            dm_we    <= memW_in;
            dm_addr  <= aluOut_in;
            dm_wdata <= gprB_in;
        end else if (state == BUSY && (dm_ack || timeoutHit)) begin
            dm_req <= 1'b0;
            dm_we  <= 1'b0;
        end
    end

    // A timed-out access retires as a bubble even though stall is already low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mw_regW   <= 1'b0;
            mw_memToR <= 1'b0;
            mw_gprDes <= 5'd0;
            mw_aluOut <= 32'd0;
            mw_rdata  <= 32'd0;
        end else begin
            if (stall || timeoutHit) begin
                mw_regW   <= 1'b0;
                mw_memToR <= 1'b0;
            end else begin
                mw_regW   <= regW_in;
                mw_memToR <= memToR_in;
                mw_gprDes <= gprDes_in;
                mw_aluOut <= aluOut_in;
            end
            if (state == BUSY && dm_ack)
                mw_rdata <= dm_rdata;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table of branch/ALU vectors, directed memory sequences,
// and a scoreboard that matches every MEM/WB register write against the instruction that produced it.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] aluOut_in, gprB_in, BPC_in, dm_addr, dm_wdata, dm_rdata;
    logic [31:0] br_target, mw_aluOut, mw_rdata;
    logic [4:0]  gprDes_in, mw_gprDes;
    logic        zero_in, pcSel_in, nbranch_in, memR_in, memW_in, regW_in, memToR_in;
    logic        dm_req, dm_we, dm_ack, stall, br_taken, mw_regW, mw_memToR, mem_err;

`ifdef MEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        logic        memR, memW, regW, memToR, pcSel, zero, nbranch;
        logic [4:0]  gprDes;
        logic [31:0] aluOut, gprB, bpc;
        logic        expTaken;
    } instrT;

    typedef struct {
        instrT       ins;
        int          busyWait;
        logic [31:0] rdata;
        int          expStall;
    } vecT;

    typedef struct {
        logic [4:0]  gprDes;
        logic [31:0] aluOut;
        logic        memToR;
        logic [31:0] rdata;
    } sbT;

    sbT sbQ[$];
    int testCount = 0;
    int failCount = 0;
    int reqRises  = 0;
    logic prevReq = 1'b0;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .aluOut_in(aluOut_in), .gprB_in(gprB_in), .gprDes_in(gprDes_in), .BPC_in(BPC_in),
        .zero_in(zero_in), .pcSel_in(pcSel_in), .nbranch_in(nbranch_in),
        .memR_in(memR_in), .memW_in(memW_in), .regW_in(regW_in), .memToR_in(memToR_in),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .stall(stall), .br_taken(br_taken), .br_target(br_target),
        .mw_regW(mw_regW), .mw_memToR(mw_memToR), .mw_gprDes(mw_gprDes),
        .mw_aluOut(mw_aluOut), .mw_rdata(mw_rdata), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic instrT mkInstr(input logic memR, memW, regW, memToR, pcSel, zero, nbranch,
                                      input logic [4:0] des, input logic [31:0] alu, gprB, bpc,
                                      input logic expTaken);
        instrT r;
        r.memR = memR; r.memW = memW; r.regW = regW; r.memToR = memToR;
        r.pcSel = pcSel; r.zero = zero; r.nbranch = nbranch;
        r.gprDes = des; r.aluOut = alu; r.gprB = gprB; r.bpc = bpc; r.expTaken = expTaken;
        return r;
    endfunction

    task automatic driveInputs(input instrT ins);
        memR_in = ins.memR; memW_in = ins.memW; regW_in = ins.regW; memToR_in = ins.memToR;
        pcSel_in = ins.pcSel; zero_in = ins.zero; nbranch_in = ins.nbranch;
        gprDes_in = ins.gprDes; aluOut_in = ins.aluOut; gprB_in = ins.gprB; BPC_in = ins.bpc;
    endtask

    // busyWait = BUSY cycles before the ack cycle; a negative value means the memory never answers.
    task automatic applyStimulus(input instrT ins, input int busyWait, input logic [31:0] rdata,
                                 input int expStall, input bit record);
        bit access;
        bit expReq;
        bit expStallNow;
        bit prevStall;
        int stallCnt;
        sbT e;
        access = ins.memR | ins.memW;
        @(negedge clk);
        driveInputs(ins);
        if (record && ins.regW) begin
            e.gprDes = ins.gprDes; e.aluOut = ins.aluOut; e.memToR = ins.memToR; e.rdata = rdata;
            sbQ.push_back(e);
        end
        stallCnt  = 0;
        prevStall = 1'b0;
        for (int cyc = 0; cyc < 64; cyc++) begin
            if (cyc > 0) @(negedge clk);
            dm_ack   = access && cyc >= 1 && (cyc - 1) == busyWait;
            dm_rdata = dm_ack ? rdata : (32'h0BAD_0000 + 32'(cyc));
            #1;
            expReq      = access && cyc >= 1;
            expStallNow = access && !(cyc >= 1 && ((cyc - 1) == busyWait ||
                                                   (TO_EN && busyWait < 0 && (cyc - 1) == 15)));
            checkOutput("dm_req", 32'(dm_req), 32'(expReq));
            if (expReq) begin
                checkOutput("dm_we", 32'(dm_we), 32'(ins.memW));
                checkOutput("dm_addr", dm_addr, ins.aluOut);
                checkOutput("dm_wdata", dm_wdata, ins.gprB);
            end
            checkOutput("stall", 32'(stall), 32'(expStallNow));
            checkOutput("br_taken", 32'(br_taken), expStallNow ? 32'd0 : 32'(ins.expTaken));
            checkOutput("br_target", br_target, ins.bpc);
            checkOutput("mem_err_idle", 32'(mem_err), 32'd0);
            if (prevStall) begin
                checkOutput("bubble_regW", 32'(mw_regW), 32'd0);
                checkOutput("bubble_memToR", 32'(mw_memToR), 32'd0);
            end
            if (stall) stallCnt++;
            prevStall = expStallNow;
            if (!expStallNow) break;
            if (cyc == 63) checkOutput("stall_bound", 32'd1, 32'd0);
        end
        checkOutput("stall_cycles", 32'(stallCnt), 32'(expStall));
    endtask

    // Every MEM/WB write with regW set must match the oldest outstanding instruction.
    always @(posedge clk) begin
        sbT e;
        #1;
        if (dm_req && !prevReq) reqRises++;
        prevReq = dm_req;
        if (rst && mw_regW) begin
            if (sbQ.size() == 0) begin
                checkOutput("sb_extra_write", 32'(mw_regW), 32'd0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("sb_gprDes", 32'(mw_gprDes), 32'(e.gprDes));
                checkOutput("sb_aluOut", mw_aluOut, e.aluOut);
                checkOutput("sb_memToR", 32'(mw_memToR), 32'(e.memToR));
                if (e.memToR) checkOutput("sb_rdata", mw_rdata, e.rdata);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecT   vecs[6];
        instrT idleIns;
        int    rises0;

        vecs[0] = '{mkInstr(0,0,1,0,1,1,0,5'd1,  32'h0000_1111, 32'h0, 32'h40, 1'b1), 0, 32'h0, 0};
        vecs[1] = '{mkInstr(0,0,1,0,1,1,1,5'd2,  32'h0000_2222, 32'h0, 32'h40, 1'b0), 0, 32'h0, 0};
        vecs[2] = '{mkInstr(0,0,0,0,1,0,1,5'd3,  32'h0000_3333, 32'h0, 32'h80, 1'b1), 0, 32'h0, 0};
        vecs[3] = '{mkInstr(0,0,1,0,1,0,0,5'd31, 32'hFFFF_FFFF, 32'h0, 32'h80, 1'b0), 0, 32'h0, 0};
        vecs[4] = '{mkInstr(0,0,1,0,0,1,0,5'd4,  32'h8000_0000, 32'h0, 32'hC,  1'b0), 0, 32'h0, 0};
        vecs[5] = '{mkInstr(0,0,1,0,0,0,1,5'd0,  32'h0000_0000, 32'h0, 32'hFFFF_FFFC, 1'b0), 0, 32'h0, 0};
        idleIns = mkInstr(0,0,0,0,0,0,0,5'd0, 32'h0, 32'h0, 32'h0, 1'b0);

        rst = 1'b0;
        driveInputs(idleIns);
        dm_ack = 1'b0;
        dm_rdata = 32'h0;
        #2;
        checkOutput("rst_dm_req", 32'(dm_req), 32'd0);
        checkOutput("rst_dm_we", 32'(dm_we), 32'd0);
        checkOutput("rst_dm_addr", dm_addr, 32'd0);
        checkOutput("rst_dm_wdata", dm_wdata, 32'd0);
        checkOutput("rst_mw_regW", 32'(mw_regW), 32'd0);
        checkOutput("rst_mw_memToR", 32'(mw_memToR), 32'd0);
        checkOutput("rst_mw_gprDes", 32'(mw_gprDes), 32'd0);
        checkOutput("rst_mw_aluOut", mw_aluOut, 32'd0);
        checkOutput("rst_mw_rdata", mw_rdata, 32'd0);
        checkOutput("rst_mem_err", 32'(mem_err), 32'd0);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 6; i++)
            applyStimulus(vecs[i].ins, vecs[i].busyWait, vecs[i].rdata, vecs[i].expStall, 1'b1);

        applyStimulus(mkInstr(1,0,1,1,0,0,0,5'd8, 32'h100, 32'h0, 32'h0, 1'b0), 1, 32'hDEAD_BEEF, 2, 1'b1);
        @(posedge clk); #1;
        checkOutput("load_mw_rdata", mw_rdata, 32'hDEAD_BEEF);
        checkOutput("load_mw_memToR", 32'(mw_memToR), 32'd1);

        applyStimulus(mkInstr(0,1,0,0,0,0,0,5'd0, 32'h204, 32'h1234_5678, 32'h0, 1'b0), 4, 32'h0, 5, 1'b1);

        rises0 = reqRises;
        applyStimulus(mkInstr(1,0,1,1,0,0,0,5'd10, 32'h180, 32'h0, 32'h0, 1'b0), 1, 32'hA5A5_0001, 2, 1'b1);
        applyStimulus(mkInstr(1,0,1,1,0,0,0,5'd11, 32'h184, 32'h0, 32'h0, 1'b0), 1, 32'h5A5A_0002, 2, 1'b1);
        @(posedge clk); #1;
        checkOutput("b2b_req_count", 32'(reqRises - rises0), 32'd2);

        applyStimulus(mkInstr(1,1,0,0,0,0,0,5'd0, 32'h300, 32'hCAFE_F00D, 32'h0, 1'b0), 1, 32'h0, 2, 1'b1);
        applyStimulus(mkInstr(1,0,1,1,1,1,0,5'd12, 32'h400, 32'h0, 32'h1000, 1'b1), 2, 32'h0F0F_0F0F, 3, 1'b1);

`ifdef MEM_TIMEOUT_EN
        applyStimulus(mkInstr(0,1,0,0,0,0,0,5'd0, 32'h500, 32'h7777_0000, 32'h0, 1'b0), -1, 32'h0, 16, 1'b0);
        @(posedge clk); #1;
        checkOutput("to_dm_req", 32'(dm_req), 32'd0);
        checkOutput("to_mem_err", 32'(mem_err), 32'd1);
        checkOutput("to_bubble", 32'(mw_regW), 32'd0);
        @(negedge clk);
        driveInputs(idleIns);
        #1;
        checkOutput("to_stall_release", 32'(stall), 32'd0);
        @(posedge clk); #1;
        checkOutput("to_mem_err_pulse", 32'(mem_err), 32'd0);
`else
        applyStimulus(mkInstr(0,1,0,0,0,0,0,5'd0, 32'h500, 32'h7777_0000, 32'h0, 1'b0), 20, 32'h0, 21, 1'b0);
`endif

        @(negedge clk);
        driveInputs(mkInstr(1,0,1,1,0,0,0,5'd9, 32'h600, 32'h0, 32'h0, 1'b0));
        @(posedge clk); #1;
        checkOutput("rb_dm_req", 32'(dm_req), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        driveInputs(idleIns);
        #1;
        checkOutput("rb_dm_req_clr", 32'(dm_req), 32'd0);
        checkOutput("rb_dm_we_clr", 32'(dm_we), 32'd0);
        checkOutput("rb_dm_addr_clr", dm_addr, 32'd0);
        checkOutput("rb_mw_aluOut_clr", mw_aluOut, 32'd0);
        checkOutput("rb_mw_rdata_clr", mw_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        dm_ack = 1'b1;
        dm_rdata = 32'hBADB_AD01;
        #1;
        checkOutput("rb_late_ack_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        checkOutput("rb_late_ack_rdata", mw_rdata, 32'd0);
        checkOutput("rb_late_ack_req", 32'(dm_req), 32'd0);
        checkOutput("rb_late_ack_regW", 32'(mw_regW), 32'd0);
        @(negedge clk);
        dm_ack = 1'b0;

        applyStimulus(mkInstr(0,0,1,0,0,0,0,5'd13, 32'h5555_AAAA, 32'h0, 32'h20, 1'b0), 0, 32'h0, 0, 1'b1);
        applyStimulus(mkInstr(1,0,1,1,0,0,0,5'd14, 32'h700, 32'h0, 32'h0, 1'b0), 1, 32'h1357_9BDF, 2, 1'b1);
        @(negedge clk);
        driveInputs(idleIns);
        repeat (2) @(posedge clk);
        #2;
        checkOutput("sb_leftover", 32'(sbQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
